// File: rtl/axi_usb_access_sched.sv
// ----------------------------------------------------------------------------
// axi_usb_access_sched : round-robin write/read burst sequencer feeding the
// USB buffer/register decoder with per-beat address and direction code.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_usb_access_sched #(
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             wr_req_valid_i,
  output logic             wr_req_ready_o,
  input  logic [31:0]      wr_req_addr_i,
  input  logic [LEN_W-1:0] wr_req_len_i,
  input  logic             wr_req_incr_i,
  input  logic             wr_beat_valid_i,
  output logic             wr_beat_ready_o,
  output logic             wr_done_o,
  input  logic             rd_req_valid_i,
  output logic             rd_req_ready_o,
  input  logic [31:0]      rd_req_addr_i,
  input  logic [LEN_W-1:0] rd_req_len_i,
  input  logic             rd_req_incr_i,
  input  logic             rd_space_i,
  output logic             rd_beat_valid_o,
  output logic             rd_last_o,
  output logic             rd_done_o,
  output logic [31:0]      dec_addr_o,
  output logic [1:0]       dec_read_en_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_WR   = 2'b10;
  localparam logic [1:0] DIR_RD   = 2'b01;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               incr_q, incr_d;
  logic               last_rd_q, last_rd_d;
  logic [31:0]        dec_addr_q, dec_addr_d;
  logic [1:0]         dec_en_q, dec_en_d;
  logic               wr_done_q, wr_done_d;
  logic               rd_tag_last_q, rd_tag_last_d;
  logic [RD_LAT-1:0]  pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0]  pipe_l_q, pipe_l_d;
  logic               grant_wr, grant_rd, issue;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    incr_d          = incr_q;
    last_rd_d       = last_rd_q;
    dec_addr_d      = dec_addr_q;
    dec_en_d        = DIR_IDLE;
    wr_done_d       = 1'b0;
    rd_tag_last_d   = 1'b0;
    wr_req_ready_o  = 1'b0;
    rd_req_ready_o  = 1'b0;
    wr_beat_ready_o = 1'b0;
    issue           = 1'b0;
    // Ties go to the channel that did not win last time.
    grant_wr        = Rst && wr_req_valid_i && (!rd_req_valid_i || last_rd_q);
    grant_rd        = Rst && rd_req_valid_i && !grant_wr;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          wr_req_ready_o = 1'b1;
          addr_d         = wr_req_addr_i;
          cnt_d          = wr_req_len_i;
          incr_d         = wr_req_incr_i;
          last_rd_d      = 1'b0;
          state_d        = WRITE;
        end else if (grant_rd) begin
          rd_req_ready_o = 1'b1;
          addr_d         = rd_req_addr_i;
          cnt_d          = rd_req_len_i;
          incr_d         = rd_req_incr_i;
          last_rd_d      = 1'b1;
          state_d        = READ;
        end
      end
      WRITE: begin
        wr_beat_ready_o = wr_beat_valid_i;
        if (wr_beat_valid_i) begin
          issue     = 1'b1;
          dec_en_d  = DIR_WR;
          wr_done_d = (cnt_q == '0);
        end
      end
      READ: begin
        if (rd_space_i) begin
          issue         = 1'b1;
          dec_en_d      = DIR_RD;
          rd_tag_last_d = (cnt_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      dec_addr_d = addr_q;
      // Increment stays inside the 256-byte window so bit 8 (space select) never flips.
      if (incr_q) addr_d = {addr_q[31:8], addr_q[7:0] + 8'd1};
      cnt_d = cnt_q - LEN_W'(1);
      if (cnt_q == '0) state_d = IDLE;
    end

    pipe_v_d[0] = (dec_en_q == DIR_RD);
    pipe_l_d[0] = rd_tag_last_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_l_d[i] = pipe_l_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      incr_q        <= 1'b0;
      last_rd_q     <= 1'b1;
      dec_addr_q    <= '0;
      dec_en_q      <= DIR_IDLE;
      wr_done_q     <= 1'b0;
      rd_tag_last_q <= 1'b0;
      pipe_v_q      <= '0;
      pipe_l_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      incr_q        <= incr_d;
      last_rd_q     <= last_rd_d;
      dec_addr_q    <= dec_addr_d;
      dec_en_q      <= dec_en_d;
      wr_done_q     <= wr_done_d;
      rd_tag_last_q <= rd_tag_last_d;
      pipe_v_q      <= pipe_v_d;
      pipe_l_q      <= pipe_l_d;
    end
  end

  assign dec_addr_o      = dec_addr_q;
  assign dec_read_en_o   = dec_en_q;
  assign wr_done_o       = wr_done_q;
  assign rd_beat_valid_o = pipe_v_q[RD_LAT-1];
  assign rd_last_o       = pipe_v_q[RD_LAT-1] & pipe_l_q[RD_LAT-1];
  assign rd_done_o       = rd_last_o;
  assign busy_o          = (state_q != IDLE) || (dec_en_q == DIR_RD) || (|pipe_v_q);

endmodule

`default_nettype wire

// File: doc/axi_usb_access_sched.md
Name: axi_usb_access_sched

Overview:
- Sequences and arbitrates all AXI-slave accesses to the USB host controller's local buffer memory and register file. It sits between the AXI write/read channel front-ends and the address decoder.
- Accepts one burst request per channel and arbitrates round-robin between write and read.
- Generates one per-beat byte address plus the 2-bit direction code (10 = write, 01 = read, 00 = idle) that drives the decoder.
- Tracks beat counts and read-return latency, and signals burst completion.

Parameters:
- LEN_W, 8, width of burst length field (value = beats-1).
- RD_LAT, 2, cycles from the dec_read_en_o=01 cycle to valid read data at the AXI read front-end.

Ports:
- Clk, input, 1, clock.
- Rst, input, 1, reset, synchronous, active-low.
- wr_req_valid_i, input, 1, write burst request valid.
- wr_req_ready_o, output, 1, write request accepted this cycle.
- wr_req_addr_i, input, 32, write start byte address.
- wr_req_len_i, input, LEN_W, write beats-1.
- wr_req_incr_i, input, 1, 1 = incrementing burst, 0 = fixed address.
- wr_beat_valid_i, input, 1, write data beat available.
- wr_beat_ready_o, output, 1, write beat consumed this cycle.
- wr_done_o, output, 1, 1-cycle pulse with the last write beat issue.
- rd_req_valid_i / rd_req_ready_o / rd_req_addr_i / rd_req_len_i / rd_req_incr_i, same widths and meaning as the write request ports, for reads.
- rd_space_i, input, 1, read front-end can absorb at least RD_LAT+1 more beats.
- rd_beat_valid_o, output, 1, read data valid at the front-end this cycle.
- rd_last_o, output, 1, qualifies the last rd_beat_valid_o of the burst.
- rd_done_o, output, 1, pulse coincident with rd_last_o.
- dec_addr_o, output, 32, byte address to the decoder (registered).
- dec_read_en_o, output, 2, direction code to the decoder (registered).
- busy_o, output, 1, high when the FSM is not IDLE or a read is in flight.

Behaviour:
- Reset: all outputs are 0.
  - FSM returns to IDLE.
  - Beat counter and address register are 0.
  - last_grant = READ, so write wins the first tie.
  - Read-latency pipeline is flushed. In-flight read data is discarded, with no rd_beat_valid_o or done pulses.
- FSM states: IDLE, WRITE, READ.
- IDLE arbitration:
  - Only one valid request: grant it.
  - Both valid: grant the channel opposite last_grant.
  - On grant: pulse the matching *_req_ready_o for 1 cycle, latch addr, len and incr, set cnt = len, update last_grant, and enter WRITE or READ on the next cycle.
  - Request ports are sampled only in IDLE.
- WRITE state:
  - wr_beat_ready_o = wr_beat_valid_i (combinational, state-qualified).
  - On each accepted beat: the next cycle drives dec_addr_o = current addr and dec_read_en_o = 10.
  - A stall (wr_beat_valid_i = 0) drives dec_read_en_o = 00 on the next cycle, with no beat consumed.
- READ state: a beat issues only when rd_space_i = 1. The next cycle drives dec_read_en_o = 01 and dec_addr_o = addr; a stall drives 00.
- Address update per issued beat:
  - Incr mode: addr[7:0] += 1 modulo 256, and addr[31:8] is held. Bursts therefore never cross between memory space (bit 8 = 0) and register space (bit 8 = 1); they wrap within the 256-byte window.
  - Fixed mode: addr is unchanged.
- Beat counting and burst end:
  - cnt decrements per issued beat.
  - The beat issued with cnt = 0 is the last: for writes wr_done_o pulses in the same cycle as that beat's dec_read_en_o; for both directions the FSM returns to IDLE.
  - len = 0 is a single beat.
- Arbitration restarts in the first IDLE cycle, so there is at least one idle dec cycle between bursts.
- Read return:
  - Each 01 cycle on dec_read_en_o is tagged into a RD_LAT-deep shift register (valid bit plus last bit).
  - rd_beat_valid_o is asserted exactly RD_LAT cycles after the corresponding 01 cycle.
  - rd_last_o and rd_done_o accompany the final beat.
- busy_o stays high until the last read beat has returned.
- A new read burst may be granted while the previous burst's data is still in flight. The pipeline keeps per-beat ordering.

Test Plan:
1. Write burst, incr: addr = 0x10, len = 3, wr_beat_valid_i held high -> dec_read_en_o = 10 for 4 consecutive cycles with dec_addr_o = 0x10, 0x11, 0x12, 0x13; wr_done_o on the 4th; then 00.
2. Read, fixed address, register space: addr = 0x104, len = 2, rd_space_i = 1 -> three 01 cycles at 0x104; rd_beat_valid_o 2 cycles after each; rd_last_o and rd_done_o on the 3rd.
3. Simultaneous write and read requests after reset -> write granted first, read granted after write completion plus one IDLE cycle. Repeat the tie -> write granted again.
4. Incr wrap: addr = 0x1FE, len = 3 -> dec_addr_o = 0x1FE, 0x1FF, 0x100, 0x101 (bit 8 preserved).
5. Stalls:
   - wr_beat_valid_i low on beat 2 of a 4-beat write -> one 00 gap, address holds, 4 beats total.
   - rd_space_i low for 3 cycles -> no 01 issue in those cycles.
6. Rst low during beat 2 of a 4-beat read -> next cycle all outputs 0, no rd_beat_valid_o for in-flight beats, FSM in IDLE, and a subsequent request is granted normally.
